// File: rtl/bldc_commutator.sv
// bldc_commutator: six-step trapezoidal commutation controller.
// Stage 1 registers the raw Hall inputs. Stage 2 validates the registered
// sample (code legality and adjacency to the last accepted code) and
// registers the active gate states. Gate polarity is applied
// combinationally on the way out so the inactive level follows inv_h/inv_l.
module bldc_commutator (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic fwd,
  input  logic in_u,
  input  logic in_v,
  input  logic in_w,
  input  logic inv_h,
  input  logic inv_l,
  output logic inv,
  output logic s_u,
  output logic s_v,
  output logic s_w,
  output logic out_uh,
  output logic out_vh,
  output logic out_wh,
  output logic out_ul,
  output logic out_vl,
  output logic out_wl
);

  // Map a Hall code (uvw) to {valid, position in the six-step sequence}.
  function automatic logic [3:0] hall_pos(input logic [2:0] code);
    logic [3:0] r;
    case (code)
      3'b001:  r = {1'b1, 3'd0};
      3'b101:  r = {1'b1, 3'd1};
      3'b100:  r = {1'b1, 3'd2};
      3'b110:  r = {1'b1, 3'd3};
      3'b010:  r = {1'b1, 3'd4};
      3'b011:  r = {1'b1, 3'd5};
      default: r = {1'b0, 3'd0};
    endcase
    return r;
  endfunction

  // Two positions are neighbours (or equal) on the circular six-step sequence.
  function automatic logic pos_adjacent(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return (d == 3'd0) || (d == 3'd1) || (d == 3'd5);
  endfunction

  // Active gate pattern {uh,vh,wh,ul,vl,wl}; reverse swaps high and low sides.
  function automatic logic [5:0] gate_table(input logic [2:0] pos, input logic dir);
    logic [5:0] t;
    case (pos)
      3'd0:    t = {3'b010, 3'b100};
      3'd1:    t = {3'b001, 3'b100};
      3'd2:    t = {3'b001, 3'b010};
      3'd3:    t = {3'b100, 3'b010};
      3'd4:    t = {3'b100, 3'b001};
      3'd5:    t = {3'b010, 3'b001};
      default: t = 6'b000000;
    endcase
    return dir ? t : {t[2:0], t[5:3]};
  endfunction

  logic [2:0] hall_r;
  logic       inv_r;
  logic [5:0] act_r;
  logic       have_prev_r;
  logic [2:0] prev_pos_r;
  logic       fwd_r;

  logic [3:0] pos_info_s;
  logic       valid_s;
  logic [2:0] pos_s;
  logic       adj_s;
  logic       dir_chg_s;
  logic       inv_nxt_s;
  logic [5:0] act_nxt_s;
  logic       have_nxt_s;
  logic [2:0] prev_nxt_s;

  assign pos_info_s = hall_pos(hall_r);
  assign valid_s    = pos_info_s[3];
  assign pos_s      = pos_info_s[2:0];
  assign adj_s      = pos_adjacent(pos_s, prev_pos_r);
  assign dir_chg_s  = (fwd != fwd_r);

  // Validation stage: decide fault flag, history update and next gate state.
  always_comb begin
    inv_nxt_s  = 1'b0;
    act_nxt_s  = 6'b000000;
    have_nxt_s = have_prev_r;
    prev_nxt_s = prev_pos_r;
    if (!enable) begin
      have_nxt_s = 1'b0;
    end else if (!valid_s) begin
      inv_nxt_s = 1'b1;
    end else if (have_prev_r && !adj_s) begin
      // Follow the jump so a stable sample at the new code clears the fault.
      inv_nxt_s  = 1'b1;
      prev_nxt_s = pos_s;
    end else begin
      have_nxt_s = 1'b1;
      prev_nxt_s = pos_s;
      if (dir_chg_s) begin
        act_nxt_s = 6'b000000;
      end else begin
        act_nxt_s = gate_table(pos_s, fwd);
      end
    end
  end

  // Hall sampling, direction tracking and registered fault/gate state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hall_r      <= 3'b000;
      inv_r       <= 1'b0;
      act_r       <= 6'b000000;
      have_prev_r <= 1'b0;
      prev_pos_r  <= 3'd0;
      fwd_r       <= fwd;
    end else begin
      hall_r      <= {in_u, in_v, in_w};
      inv_r       <= inv_nxt_s;
      act_r       <= act_nxt_s;
      have_prev_r <= have_nxt_s;
      prev_pos_r  <= prev_nxt_s;
      fwd_r       <= fwd;
    end
  end

  assign inv    = inv_r;
  assign s_u    = hall_r[2];
  assign s_v    = hall_r[1];
  assign s_w    = hall_r[0];
  assign out_uh = act_r[5] ^ inv_h;
  assign out_vh = act_r[4] ^ inv_h;
  assign out_wh = act_r[3] ^ inv_h;
  assign out_ul = act_r[2] ^ inv_l;
  assign out_vl = act_r[1] ^ inv_l;
  assign out_wl = act_r[0] ^ inv_l;

endmodule

// File: tb/tb_bldc_commutator.sv
// Testbench for bldc_commutator: directed test-plan sequence followed by
// randomized Hall/enable/direction/polarity/reset stimulus, checked by a
// queue-based scoreboard against a sequence-level reference model.
`timescale 1ns/1ps
module tb_bldc_commutator;

  logic clk = 1'b0;
  logic reset, enable, fwd, in_u, in_v, in_w, inv_h, inv_l;
  logic inv, s_u, s_v, s_w;
  logic out_uh, out_vh, out_wh, out_ul, out_vl, out_wl;

  bldc_commutator dut (
    .clk(clk), .reset(reset), .enable(enable), .fwd(fwd),
    .in_u(in_u), .in_v(in_v), .in_w(in_w), .inv_h(inv_h), .inv_l(inv_l),
    .inv(inv), .s_u(s_u), .s_v(s_v), .s_w(s_w),
    .out_uh(out_uh), .out_vh(out_vh), .out_wh(out_wh),
    .out_ul(out_ul), .out_vl(out_vl), .out_wl(out_wl)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [2:0] s;
    logic       flag;
    logic [5:0] g;   // {uh,vh,wh,ul,vl,wl}
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Stimulus settings applied at the next step
  bit rst_v, en_v, fwd_v, ih_v, il_v;

  // Reference model state: what the DUT's validation stage sees
  int seq[6]      = '{1, 5, 4, 6, 2, 3};   // S0..S5 as uvw codes
  int hi_phase[6] = '{1, 2, 2, 0, 0, 1};   // forward table: 0=u 1=v 2=w
  int lo_phase[6] = '{0, 0, 1, 1, 2, 2};
  int m_s;
  bit m_have;
  int m_prev;
  bit m_fwd_r;

  function automatic int find_pos(input int code);
    for (int i = 0; i < 6; i++) if (seq[i] == code) return i;
    return -1;
  endfunction

  function automatic logic [5:0] pol_mask(input bit ih, input bit il);
    return {ih, ih, ih, il, il, il};
  endfunction

  // Expected gate pattern (active states) for step p in direction d
  function automatic logic [5:0] expect_gates(input int p, input bit d);
    logic [5:0] a;
    int hp, lp;
    a = 6'b000000;
    hp = d ? hi_phase[p] : lo_phase[p];
    lp = d ? lo_phase[p] : hi_phase[p];
    a[5 - hp] = 1'b1;
    a[2 - lp] = 1'b1;
    return a;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model one rising edge with the inputs just driven; push the expectation.
  task automatic model_edge(input int h);
    exp_t e;
    logic [5:0] act;
    int p, d;
    bit dir_chg;
    act = 6'b000000;
    if (rst_v) begin
      e.s = 3'b000; e.flag = 1'b0;
      m_s = 0; m_have = 0; m_fwd_r = fwd_v;
    end else begin
      dir_chg = (fwd_v != m_fwd_r);
      m_fwd_r = fwd_v;
      e.flag = 1'b0;
      p = find_pos(m_s);
      if (!en_v) begin
        m_have = 0;
      end else if (p < 0) begin
        e.flag = 1'b1;
      end else begin
        d = (p - m_prev + 6) % 6;
        if (m_have && !(d == 0 || d == 1 || d == 5)) begin
          e.flag = 1'b1;
        end else begin
          m_have = 1;
          if (!dir_chg) act = expect_gates(p, fwd_v);
        end
        m_prev = p;
      end
      m_s = h;
      e.s = h[2:0];
    end
    e.g = act ^ pol_mask(ih_v, il_v);
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: drive on the falling edge, then model the next rise.
  task automatic step(input int h);
    bit was_rst;
    @(negedge clk);
    was_rst = reset;
    reset = rst_v; enable = en_v; fwd = fwd_v;
    {in_u, in_v, in_w} = h[2:0];
    inv_h = ih_v; inv_l = il_v;
    if (rst_v && !was_rst) begin
      #1;
      check("async_reset_gates", {out_uh, out_vh, out_wh, out_ul, out_vl, out_wl},
            pol_mask(ih_v, il_v));
      check("async_reset_inv", inv, 0);
    end
    model_edge(h);
  endtask

  task automatic hold(input int h, input int n);
    for (int i = 0; i < n; i++) step(h);
  endtask

  // Monitor: each rising edge the DUT presents a new registered result.
  initial begin : monitor
    exp_t e;
    logic [5:0] g, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {out_uh, out_vh, out_wh, out_ul, out_vl, out_wl};
        check("hall_sample", {s_u, s_v, s_w}, e.s);
        check("inv_flag", inv, e.flag);
        check("gates", g, e.g);
        a = g ^ pol_mask(inv_h, inv_l);
        check("shoot_through", a[5:3] & a[2:0], 0);
      end
    end
  end

  initial begin : stim
    int pos, r, h;
    reset = 1'b1; enable = 1'b1; fwd = 1'b1;
    {in_u, in_v, in_w} = 3'b000; inv_h = 1'b0; inv_l = 1'b0;
    rst_v = 1; en_v = 1; fwd_v = 1; ih_v = 0; il_v = 0;
    m_s = 0; m_have = 0; m_prev = 0; m_fwd_r = 1;
    #1;
    check("reset_gates", {out_uh, out_vh, out_wh, out_ul, out_vl, out_wl}, 0);
    check("reset_inv", inv, 0);
    check("reset_sample", {s_u, s_v, s_w}, 0);

    // Reset release with halls at 000: fault once sampled
    hold(0, 1);
    rst_v = 0;
    hold(0, 3);

    // Forward sweep with back-glitches
    for (int k = 0; k < 14; k++) begin
      pos = k % 6;
      if (k % 2 == 1) begin
        hold(seq[pos], 3);
        hold(seq[(pos + 5) % 6], 1);
        hold(seq[pos], 2);
      end else begin
        hold(seq[pos], 5);
      end
    end
    // Reverse at S3, direction change blanking
    hold(seq[3], 3);
    fwd_v = 0;
    hold(seq[3], 4);
    // Faults: 111, then jump S0 -> S3
    hold(7, 3);
    hold(seq[3], 3);
    hold(seq[4], 2);
    hold(seq[5], 2);
    hold(seq[0], 3);
    hold(seq[3], 3);
    // Polarity in S0 forward
    fwd_v = 1;
    hold(seq[0], 3);
    ih_v = 1; il_v = 1;
    hold(seq[0], 3);
    ih_v = 0; il_v = 0;
    // Enable off, re-enable at S2
    en_v = 0;
    hold(seq[1], 2);
    hold(seq[2], 2);
    en_v = 1;
    hold(seq[2], 4);
    // Mid-run reset
    rst_v = 1;
    hold(seq[2], 2);
    rst_v = 0;
    hold(seq[5], 3);

    // Randomized stimulus
    pos = 5;
    h = seq[pos];
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r >= 60 && r < 85) begin
        pos = (pos + (($urandom_range(0, 1) == 1) ? 1 : 5)) % 6;
        h = seq[pos];
      end else if (r >= 85 && r < 93) begin
        h = $urandom_range(0, 7);
        if (find_pos(h) >= 0) pos = find_pos(h);
      end else if (r >= 93) begin
        h = seq[pos];
      end
      if ($urandom_range(0, 99) < 3) fwd_v = !fwd_v;
      if ($urandom_range(0, 99) < 2) en_v = !en_v;
      if ($urandom_range(0, 99) < 2) begin
        ih_v = $urandom_range(0, 1);
        il_v = $urandom_range(0, 1);
      end
      rst_v = ($urandom_range(0, 199) == 0);
      step(h);
    end
    rst_v = 0;
    hold(h, 2);

    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
